// File: rtl/protocore_pkg.sv
// Shared ProtoCore register-file constants and data/address types.
package protocore_pkg;

    localparam int unsigned REG_DATA_W = 8;
    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned REG_DEPTH  = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file.sv
// ProtoCore general-purpose register file: two combinational read ports,
// one synchronous write port, asynchronous active-high clear.
module reg_file
    import protocore_pkg::*;
#(
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DEPTH  = REG_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              we,
    output logic [DATA_W-1:0] read_a,
    output logic [DATA_W-1:0] read_b
);

    // Every address must map to a register, so no range check on the ports.
    if (DEPTH != (32'd1 << ADDR_W)) begin : g_depth_check
        $error("reg_file: DEPTH must equal 2**ADDR_W");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    // Reset dominates any write in the same cycle; r0 is an ordinary register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    // No write-through: a read of wa shows the old value until the edge.
    assign read_a = mem[ra];
    assign read_b = mem[rb];

    // A committed write must be visible on the following cycle.
    a_write_lands: assert property (
        @(posedge clk) disable iff (rst)
        we |=> (mem[$past(wa)] == $past(wd))
    );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues expectations, monitor compares.
module tb_reg_file;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] ra  = '0;
    logic [3:0] rb  = '0;
    logic [3:0] wa  = '0;
    logic [7:0] wd  = '0;
    logic       we  = 1'b0;
    logic [7:0] read_a;
    logic [7:0] read_b;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    exp_t q[$];
    event chk;
    int   passed = 0;
    int   total  = 0;

    reg_file dut (
        .clk    (clk),
        .rst    (rst),
        .ra     (ra),
        .rb     (rb),
        .wa     (wa),
        .wd     (wd),
        .we     (we),
        .read_a (read_a),
        .read_b (read_b)
    );

    always #5 clk = ~clk;

    // Monitor: samples the read ports 1ns after each strobe and pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(chk);
            #1;
            total++;
            if (q.size() == 0) begin
                $display("FAIL %s: no expectation queued (read_a=%02h read_b=%02h)",
                         "scoreboard", read_a, read_b);
            end else begin
                e = q.pop_front();
                if (read_a === e.a && read_b === e.b) begin
                    passed++;
                end else begin
                    $display("FAIL %s: read_a=%02h read_b=%02h expected %02h %02h",
                             e.name, read_a, read_b, e.a, e.b);
                end
            end
        end
    end

    task automatic expect_rd(input string name, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.name = name;
        e.a    = a;
        e.b    = b;
        q.push_back(e);
        -> chk;
        #2;
    endtask

    task automatic write_reg(input logic [3:0] addr, input logic [7:0] data);
        we = 1'b1;
        wa = addr;
        wd = data;
        @(negedge clk);
        we = 1'b0;
    endtask

    // Stimulus: directed vectors with hand-computed expectations.
    initial begin
        #1 rst = 1'b1;
        ra = 4'd0;
        rb = 4'd15;
        expect_rd("reset_r0_r15", 8'h00, 8'h00);
        ra = 4'd6;
        rb = 4'd6;
        expect_rd("reset_r6", 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Fill r_i with i*0x11.
        for (int i = 0; i < 16; i++) begin
            write_reg(4'(i), 8'(i * 8'h11));
        end
        for (int i = 0; i < 16; i++) begin
            ra = 4'(i);
            rb = 4'(15 - i);
            expect_rd($sformatf("fill_%0d", i), 8'(i * 8'h11), 8'(((15 - i) * 8'h11)));
        end

        @(negedge clk);
        write_reg(4'd3, 8'hAA);
        ra = 4'd3;
        rb = 4'd3;
        expect_rd("overwrite_r3", 8'hAA, 8'hAA);

        @(negedge clk);
        we = 1'b0;
        wa = 4'd5;
        wd = 8'h11;
        @(negedge clk);
        ra = 4'd5;
        rb = 4'd5;
        expect_rd("we_off_r5", 8'h55, 8'h55);

        @(negedge clk);
        we = 1'b1;
        wa = 4'd7;
        wd = 8'h3C;
        ra = 4'd7;
        rb = 4'd7;
        expect_rd("no_bypass_before", 8'h77, 8'h77);
        @(negedge clk);
        we = 1'b0;
        expect_rd("no_bypass_after", 8'h3C, 8'h3C);

        @(negedge clk);
        write_reg(4'd0, 8'h5A);
        ra = 4'd0;
        rb = 4'd0;
        expect_rd("r0_dual_port", 8'h5A, 8'h5A);
        ra = 4'd9;
        rb = 4'd2;
        expect_rd("pre_reset_r9_r2", 8'h99, 8'h22);

        // Reset mid-run, with a write to r9 pending; clear is immediate and wins.
        @(negedge clk);
        we  = 1'b1;
        wa  = 4'd9;
        wd  = 8'hEE;
        rst = 1'b1;
        expect_rd("async_clear_r9_r2", 8'h00, 8'h00);
        for (int i = 0; i < 16; i++) begin
            ra = 4'(i);
            rb = 4'(15 - i);
            expect_rd($sformatf("reset_all_%0d", i), 8'h00, 8'h00);
        end
        @(negedge clk);
        we  = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        ra = 4'd9;
        rb = 4'd9;
        expect_rd("write_during_reset_dropped", 8'h00, 8'h00);

        write_reg(4'd9, 8'h42);
        expect_rd("write_after_reset", 8'h42, 8'h42);

        #5;
        if (q.size() != 0) begin
            total++;
            $display("FAIL %s: %0d expectations left unchecked", "drain", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- General-purpose register file for the ProtoCore datapath: 16 registers x 8 bits.
- Two independent combinational read ports (A, B) feed the ALU operand paths.
- One synchronous write port with write enable, driven from the writeback stage.
- All registers clear to zero on asynchronous reset.

Parameters:
- DATA_W, 8, width of each register and of the data ports.
- ADDR_W, 4, width of the address ports.
- DEPTH, 16, number of registers. Must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; the write port is sampled on its rising edge.
- rst  input  1  asynchronous, active-high reset; clears every register.
- ra  input  ADDR_W  read port A address.
- rb  input  ADDR_W  read port B address.
- wa  input  ADDR_W  write address.
- wd  input  DATA_W  write data.
- we  input  1  write enable, active high.
- read_a  output  DATA_W  contents of register ra.
- read_b  output  DATA_W  contents of register rb.

Interface decision: one clock (clk); reset rst is asynchronous and active-high.

Behaviour:
- Storage: DEPTH registers of DATA_W bits. Register 0 is an ordinary writable register, not hardwired to zero.
- Reset:
  - rst high immediately forces all registers to 0, independent of clk.
  - read_a and read_b therefore read 0x00 while rst is asserted and until the first write.
  - Reset release takes effect at the next rising edge of clk.
- Write:
  - On rising clk with rst low and we=1, mem[wa] <= wd.
  - we=0: no register changes, whatever the values of wa and wd.
  - Write latency is one edge: the new value is visible on the read ports after that edge.
- Read:
  - Purely combinational: read_a = mem[ra], read_b = mem[rb].
  - There is no read latency; an address change propagates within the same cycle.
- Simultaneous events:
  - ra == rb is legal; both ports return the same value.
  - Reading wa in the cycle of its write returns the OLD value until the clock edge. There is no write-through bypass.
  - A write concurrent with rst is discarded; reset wins.
- Addresses are always in range (DEPTH = 2**ADDR_W), so there is no out-of-range case.
- No X on outputs after reset. Before the first reset the contents are unspecified.

Decomposition:
- Shared package (protocore_pkg):
  - constants REG_DATA_W=8, REG_ADDR_W=4, REG_DEPTH=16;
  - typedefs reg_addr_t (logic [3:0]) and reg_data_t (logic [7:0]).
- Sub-modules: none required. A single module holding the array, the write always-block with async reset, and two continuous read assigns is sufficient.
- Optional parameter assertions (DEPTH == 2**ADDR_W) and SVA checks belong in the same file.

Test Plan:
- Reset: assert rst mid-run after writes -> all 16 registers read 0x00 on both ports, without waiting for a clk edge.
- Fill: write i*0x11 to register i for i=0..15 with we=1 (0x00, 0x11 .. 0xFF) -> then, with we=0, read ra=i and rb=15-i for all i: read_a = i*0x11, read_b = (15-i)*0x11.
- Overwrite: we=1, wa=3, wd=0xAA, one edge; then ra=rb=3 -> read_a = read_b = 0xAA.
- Write-enable off: we=0, wa=5, wd=0x11, one edge; ra=5 -> read_a stays 0x55.
- No bypass: we=1, wa=7, wd=0x3C, ra=7 before the edge -> read_a shows the old 0x77; after the edge, 0x3C.
- Dual-port same address and register 0: write 0x5A to r0; ra=rb=0 -> both ports read 0x5A.
